// File: rtl/alu_arb_pkg.sv
// Shared definitions for the two-requester ALU arbiter:
// opcodes, FSM state encoding and requester count.
package alu_arb_pkg;

   localparam int NUM_REQ = 2;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_MUL = 3'd5;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MUL  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/alu_core.sv
// Combinational W-bit ALU for ADD/SUB/AND/OR/XOR; any other opcode
// (including MUL, handled iteratively by the caller) gives y=0, err=1.
// Ports: a_i, b_i operands; op_i opcode; y_o result; carry_o ADD
// carry / SUB borrow; err_o illegal-opcode flag.
module alu_core
   import alu_arb_pkg::*;
#(
   parameter int W = 8
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic [2:0]   op_i,
   output logic [W-1:0] y_o,
   output logic         carry_o,
   output logic         err_o
);

   always_comb begin
      y_o     = '0;
      carry_o = 1'b0;
      err_o   = 1'b0;
      case (op_i)
         OP_ADD: {carry_o, y_o} = {1'b0, a_i} + {1'b0, b_i};
         OP_SUB: begin
            y_o     = a_i - b_i;
            carry_o = (a_i < b_i);
         end
         OP_AND: y_o = a_i & b_i;
         OP_OR:  y_o = a_i | b_i;
         OP_XOR: y_o = a_i ^ b_i;
         default: err_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one W-bit ALU between two requesters.
// Ports: clk, rst (async, active-high); req_valid/req_ready and
// req_a*/req_b*/req_op* per requester; out_valid/out_ready result
// handshake with out_id, out_y, out_carry, out_err.
module alu_arbiter
   import alu_arb_pkg::*;
#(
   parameter int W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req_valid,
   output logic [NUM_REQ-1:0] req_ready,
   input  logic [W-1:0]       req_a0,
   input  logic [W-1:0]       req_b0,
   input  logic [2:0]         req_op0,
   input  logic [W-1:0]       req_a1,
   input  logic [W-1:0]       req_b1,
   input  logic [2:0]         req_op1,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               out_id,
   output logic [W-1:0]       out_y,
   output logic               out_carry,
   output logic               out_err
);

   localparam int CW = $clog2(W + 1);

   logic [1:0]    state_q, state_d;
   logic          last_q, last_d;
   logic          id_q, id_d;
   logic [W-1:0]  a_q, a_d;
   logic [W-1:0]  b_q, b_d;
   logic [W-1:0]  y_q, y_d;
   logic          carry_q, carry_d;
   logic          err_q, err_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic          win;
   logic          grant;
   logic [W-1:0]  sel_a, sel_b;
   logic [2:0]    sel_op;
   logic [W-1:0]  core_y;
   logic          core_c, core_e;

   // On a tie the requester not served last wins.
   always_comb begin
      win = 1'b0;
      unique case (req_valid)
         2'b01:   win = 1'b0;
         2'b10:   win = 1'b1;
         2'b11:   win = ~last_q;
         default: win = 1'b0;
      endcase
   end

   assign grant     = (state_q == ST_IDLE) && !rst && |req_valid;
   assign req_ready = grant ? (win ? 2'b10 : 2'b01) : 2'b00;

   assign sel_a  = win ? req_a1  : req_a0;
   assign sel_b  = win ? req_b1  : req_b0;
   assign sel_op = win ? req_op1 : req_op0;

   alu_core #(.W(W)) u_core (
      .a_i     (sel_a),
      .b_i     (sel_b),
      .op_i    (sel_op),
      .y_o     (core_y),
      .carry_o (core_c),
      .err_o   (core_e)
   );

   // ST_MUL is the execute slot for every op: single-cycle ops enter
   // it with the result already latched and cnt preset to W, so they
   // spend exactly one cycle there before DONE.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      id_d    = id_q;
      a_d     = a_q;
      b_d     = b_q;
      y_d     = y_q;
      carry_d = carry_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (grant) begin
               last_d  = win;
               id_d    = win;
               a_d     = sel_a;
               b_d     = sel_b;
               state_d = ST_MUL;
               if (sel_op == OP_MUL) begin
                  y_d     = '0;
                  carry_d = 1'b0;
                  err_d   = 1'b0;
                  cnt_d   = '0;
               end else begin
                  y_d     = core_y;
                  carry_d = core_c;
                  err_d   = core_e;
                  cnt_d   = CW'(W);
               end
            end
         end
         ST_MUL: begin
            if (cnt_q == CW'(W)) begin
               state_d = ST_DONE;
            end else begin
               if (b_q[0]) y_d = y_q + a_q;
               a_d   = a_q << 1;
               b_d   = b_q >> 1;
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_DONE: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         last_q  <= 1'b1;
         id_q    <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         y_q     <= '0;
         carry_q <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         id_q    <= id_d;
         a_q     <= a_d;
         b_q     <= b_d;
         y_q     <= y_d;
         carry_q <= carry_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   // Result fields read as zero unless a result is being offered,
   // which hides the partial MUL accumulator.
   assign out_valid = (state_q == ST_DONE);
   assign out_id    = out_valid ? id_q    : 1'b0;
   assign out_y     = out_valid ? y_q     : '0;
   assign out_carry = out_valid ? carry_q : 1'b0;
   assign out_err   = out_valid ? err_q   : 1'b0;

endmodule
